// File: rtl/modif_sender.sv
// Consumer side of the modification-tracking handshake: frames the modified
// buffer range as start, end, data bytes over valid/ready. Optional checksum byte: MODIF_SENDER_CSUM_EN.
module modif_sender #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int HOLDOFF = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          is_modif,
   input  logic [AW-1:0] modif_start,
   input  logic [AW-1:0] modif_end,
   output logic          in_send,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic [DW-1:0] tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          busy
);

`ifdef MODIF_SENDER_CSUM_EN
   typedef enum logic [3:0] {IDLE, ARM, HDR_S, HDR_E, RD, CAP, DATA, CSUM, DONE} state_t;
`else
   typedef enum logic [3:0] {IDLE, ARM, HDR_S, HDR_E, RD, CAP, DATA, DONE} state_t;
`endif

   localparam int HW = $clog2(HOLDOFF + 1);

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic [AW-1:0] a_q;
   logic [AW-1:0] e_q;
   logic [DW-1:0] tx_q;
   logic          xfer;
`ifdef MODIF_SENDER_CSUM_EN
   logic [DW-1:0] acc;
`endif

   assign xfer = tx_valid && tx_ready;

   // The checker's range only becomes valid in the HDR_S cycle itself, so the
   // start byte is taken straight from modif_start there; it is held stable
   // by the checker for the whole send.
   assign tx_data = (state == HDR_S) ? DW'(modif_start) : tx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         in_send  <= 1'b0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         tx_q     <= '0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         hold_cnt <= HW'(HOLDOFF);
         a_q      <= '0;
         e_q      <= '0;
`ifdef MODIF_SENDER_CSUM_EN
         acc      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - 1'b1;
               end else if (is_modif) begin
                  state   <= ARM;
                  in_send <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            ARM: begin
               state    <= HDR_S;
               tx_valid <= 1'b1;
`ifdef MODIF_SENDER_CSUM_EN
               acc      <= '0;
`endif
            end
            HDR_S: begin
               if (xfer) begin
                  a_q   <= modif_start;
                  e_q   <= modif_end;
                  tx_q  <= DW'(modif_end);
                  state <= HDR_E;
`ifdef MODIF_SENDER_CSUM_EN
                  acc   <= acc + DW'(modif_start);
`endif
               end
            end
            HDR_E: begin
               if (xfer) begin
                  tx_valid <= 1'b0;
                  rd_en    <= 1'b1;
                  rd_addr  <= a_q;
                  state    <= RD;
`ifdef MODIF_SENDER_CSUM_EN
                  acc      <= acc + tx_q;
`endif
               end
            end
            RD: begin
               rd_en <= 1'b0;
               state <= CAP;
            end
            CAP: begin
               tx_q     <= rd_data;
               tx_valid <= 1'b1;
               state    <= DATA;
            end
            DATA: begin
               if (xfer) begin
                  // Equality stop condition bounds the frame even when e < s.
                  if (a_q == e_q) begin
`ifdef MODIF_SENDER_CSUM_EN
                     tx_q  <= ~(acc + tx_q) + 1'b1;
                     state <= CSUM;
`else
                     tx_valid <= 1'b0;
                     in_send  <= 1'b0;
                     state    <= DONE;
`endif
                  end else begin
                     a_q      <= a_q + 1'b1;
                     rd_addr  <= a_q + 1'b1;
                     rd_en    <= 1'b1;
                     tx_valid <= 1'b0;
                     state    <= RD;
`ifdef MODIF_SENDER_CSUM_EN
                     acc      <= acc + tx_q;
`endif
                  end
               end
            end
`ifdef MODIF_SENDER_CSUM_EN
            CSUM: begin
               if (xfer) begin
                  tx_valid <= 1'b0;
                  in_send  <= 1'b0;
                  state    <= DONE;
               end
            end
`endif
            DONE: begin
               hold_cnt <= HW'(HOLDOFF);
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_modif_sender.sv
// Randomised bench for modif_sender: a checker/buffer/sink model around the DUT
// and a frame reference built from the range and buffer contents.
module tb_modif_sender;
   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int HOLDOFF = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          is_modif;
   logic [AW-1:0] modif_start;
   logic [AW-1:0] modif_end;
   logic          in_send;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          busy;

   logic [AW-1:0] rng_s;
   logic [AW-1:0] rng_e;
   logic [DW-1:0] mem [0:255];
   logic [7:0]    exp_q [$];
   int            exp_n;
   int            n_checks = 0;
   int            n_pass   = 0;

   always #5 clk = ~clk;

   modif_sender #(.AW(AW), .DW(DW), .HOLDOFF(HOLDOFF)) dut (
      .clk(clk), .rst(rst), .is_modif(is_modif),
      .modif_start(modif_start), .modif_end(modif_end),
      .in_send(in_send), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
   );

   // Buffer with one-cycle read latency (garbage otherwise); checker range
   // is only valid from the second in_send cycle on.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      else       rd_data <= DW'($urandom);
      if (in_send) begin
         modif_start <= rng_s;
         modif_end   <= rng_e;
      end else begin
         modif_start <= ~rng_s;
         modif_end   <= ~rng_e;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic build_expected(input logic [7:0] s, input logic [7:0] e);
      int sum;
      exp_q = {};
      exp_n = int'(8'(e - s)) + 1;
      exp_q.push_back(s);
      exp_q.push_back(e);
      for (int i = 0; i < exp_n; i++) exp_q.push_back(mem[(int'(s) + i) % 256]);
`ifdef MODIF_SENDER_CSUM_EN
      sum = 0;
      foreach (exp_q[i]) sum += int'(exp_q[i]);
      exp_q.push_back(8'((256 - (sum % 256)) % 256));
`else
      sum = 0;
`endif
   endtask

   // mode: 0 always ready, 1 toggle every 3 cycles, 2 random.
   // abort_at >= 0 returns while that many bytes are done and the next is offered.
   task automatic run_frame(input logic [7:0] s, input logic [7:0] e, input int mode,
                            input bit hold, input int abort_at, output int gap);
      logic [7:0] got [$];
      logic [7:0] first_rd;
      logic [7:0] prev_d;
      int         rd_cnt;
      int         t_val;
      int         k;
      bit         prev_stall;
      bit         done;
      bit         not_busy;
      build_expected(s, e);
      rng_s = s; rng_e = e; is_modif = 1'b1;
      gap = 0; k = 0; rd_cnt = 0; t_val = -1; prev_stall = 0; done = 0; not_busy = 0;
      first_rd = '0; prev_d = '0;
      while (!in_send && k < 200) begin
         gap++; k++;
         @(negedge clk);
      end
      if (!in_send) begin
         check("start_timeout", 0, 1);
         return;
      end
      for (int c = 0; c < 4000; c++) begin
         if (!hold) is_modif = 1'b0;
         case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ((c / 3) % 2) == 1;
            default: tx_ready = 1'($urandom);
         endcase
         if (!busy) not_busy = 1;
         if (tx_valid && t_val < 0) t_val = c;
         if (prev_stall) check("stall_hold", {tx_valid, tx_data}, {1'b1, prev_d});
         if (rd_en) begin
            if (rd_cnt == 0) first_rd = rd_addr;
            rd_cnt++;
         end
         if (abort_at >= 0 && got.size() == abort_at && tx_valid) begin
            tx_ready = 1'b0;
            return;
         end
         if (tx_valid && tx_ready) got.push_back(tx_data);
         prev_stall = tx_valid && !tx_ready;
         prev_d     = tx_data;
         if (got.size() == exp_q.size()) begin
            done = 1;
            break;
         end
         @(negedge clk);
      end
      if (!done) check("frame_timeout", 0, 1);
      @(negedge clk);
      check("in_send_fall", in_send, 0);
      check("tx_valid_fall", tx_valid, 0);
      check("busy_during_send", not_busy, 0);
      check("first_valid_latency", t_val, 1);
      check("n_bytes", got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         check($sformatf("byte%0d", i), got[i], exp_q[i]);
      check("rd_pulses", rd_cnt, exp_n);
      check("rd_first_addr", first_rd, s);
   endtask

   initial begin
      int         gap;
      bit         act;
      logic [7:0] s;
      logic [7:0] e;
      int         len;
      rst = 1'b1; is_modif = 1'b0; tx_ready = 1'b0; rng_s = '0; rng_e = '0;
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
      repeat (3) @(negedge clk);
      check("rst_in_send", in_send, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;

      mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC;
      run_frame(8'h10, 8'h12, 0, 0, -1, gap);

      mem[8'h7F] = 8'h5A;
      run_frame(8'h7F, 8'h7F, 0, 0, -1, gap);

      run_frame(8'h00, 8'h01, 1, 0, -1, gap);

      run_frame(8'h30, 8'h31, 0, 1, -1, gap);
      run_frame(8'h20, 8'h21, 0, 0, -1, gap);
      check("rearm_gap_ok", gap >= HOLDOFF + 1, 1);

      repeat (6) begin
         s   = 8'($urandom);
         len = $urandom_range(0, 15);
         e   = (int'(s) + len > 255) ? 8'hFF : 8'(int'(s) + len);
         run_frame(s, e, 2, 0, -1, gap);
      end

      run_frame(8'h00, 8'hFF, 2, 0, -1, gap);

      run_frame(8'h40, 8'h43, 0, 0, 3, gap);
      rst = 1'b1; is_modif = 1'b0;
      @(negedge clk);
      check("abort_in_send", in_send, 0);
      check("abort_tx_valid", tx_valid, 0);
      check("abort_busy", busy, 0);
      rst = 1'b0;
      act = 0;
      repeat (20) begin
         @(negedge clk);
         if (in_send || tx_valid || rd_en || busy) act = 1;
      end
      check("quiet_after_abort", act, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
